// File: rtl/wb_network_v_pkg.sv
`default_nettype none
// ============================================================================
// Module : pkg_tpu
// Desc   : Shared types and widths for the TPU write-back network.
// Rev    : 1.0 - initial release
// ============================================================================
package pkg_tpu;

    localparam int NUM_WB_SRC = 3;
    localparam int IDX_W      = 5;
    localparam int DATA_W     = 32;

    typedef logic [IDX_W-1:0]  index_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        index_t idx;
        data_t  data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_network_v_fifo.sv
`default_nettype none
// ============================================================================
// Module : WB_FIFO
// Desc   : Per-source result buffer; head entry is visible combinationally.
// Rev    : 1.0 - initial release
// ============================================================================
module WB_FIFO
    import pkg_tpu::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wb_entry_t i_entry,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int            c_AW   = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0] c_FULL = FIFO_DEPTH[c_AW:0];

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    wb_entry_t       r_mem [FIFO_DEPTH];
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_entry;
    end

endmodule
`default_nettype wire

// File: rtl/wb_network_v.sv
`default_nettype none
// ============================================================================
// Module : wb_network_v
// Desc   : Round-robin write-back arbiter over per-source FIFOs.
//          Optional forwarding outputs enabled by WB_NETWORK_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module wb_network_v
    import pkg_tpu::*;
#(
    parameter int NUM_SRC    = NUM_WB_SRC,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   I_Valid,
    input  index_t [NUM_SRC-1:0] I_DstIdx,
    input  data_t  [NUM_SRC-1:0] I_Data,
    output logic [NUM_SRC-1:0]   O_Ready,
    input  logic                 I_Stall,
    output logic                 O_WB_Req,
    output index_t               O_WB_DstIdx,
    output data_t                O_WB_Data,
    output logic                 O_Bypass_Valid,
    output index_t               O_Bypass_DstIdx,
    output data_t                O_Bypass_Data,
    output logic                 O_Empty
);

    localparam int c_PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_pop;
    wb_entry_t          w_head  [NUM_SRC];
    wb_entry_t          w_entry [NUM_SRC];

    logic [c_PW-1:0]    r_ptr;
    logic [c_PW-1:0]    w_gnt_idx;
    logic [c_PW-1:0]    w_ptr_nxt;
    logic               w_gnt;
    int                 w_cand;

    logic               r_wb_req;
    wb_entry_t          r_wb_entry;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
            assign w_entry[s] = '{idx: I_DstIdx[s], data: I_Data[s]};

            WB_FIFO #(
                .FIFO_DEPTH(FIFO_DEPTH)
            ) u_fifo (
                .clk     (clock),
                .rst     (reset),
                .i_push  (I_Valid[s] & ~w_full[s]),
                .i_entry (w_entry[s]),
                .i_pop   (w_pop[s]),
                .o_head  (w_head[s]),
                .o_full  (w_full[s]),
                .o_empty (w_empty[s])
            );
        end
    endgenerate

    // Ready comes from registered occupancy only, so a full FIFO stays closed
    // even on the cycle it is being drained.
    assign O_Ready = ~w_full;

    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        w_cand    = 0;
        w_pop     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= NUM_SRC) w_cand = w_cand - NUM_SRC;
            if (!w_gnt && !I_Stall && !w_empty[w_cand]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = c_PW'(w_cand);
            end
        end
        if (w_gnt) w_pop[w_gnt_idx] = 1'b1;
    end

    assign w_ptr_nxt = (w_gnt_idx == c_PW'(NUM_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_wb_req   <= 1'b0;
            r_wb_entry <= '0;
        end else begin
            r_wb_req   <= w_gnt;
            r_wb_entry <= w_gnt ? w_head[w_gnt_idx] : '0;
            if (w_gnt) r_ptr <= w_ptr_nxt;
        end
    end

    assign O_WB_Req    = r_wb_req;
    assign O_WB_DstIdx = r_wb_entry.idx;
    assign O_WB_Data   = r_wb_entry.data;
    assign O_Empty     = (&w_empty) & ~r_wb_req;

`ifdef WB_NETWORK_BYPASS_EN
    assign O_Bypass_Valid  = r_wb_req;
    assign O_Bypass_DstIdx = r_wb_entry.idx;
    assign O_Bypass_Data   = r_wb_entry.data;
`else
    assign O_Bypass_Valid  = 1'b0;
    assign O_Bypass_DstIdx = '0;
    assign O_Bypass_Data   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_network_v.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_network_v
// Desc   : Self-checking bench for wb_network_v against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_wb_network_v;
    import pkg_tpu::*;

    localparam int NS    = 3;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NS-1:0]     I_Valid;
    index_t [NS-1:0]   I_DstIdx;
    data_t  [NS-1:0]   I_Data;
    logic [NS-1:0]     O_Ready;
    logic              I_Stall;
    logic              O_WB_Req;
    index_t            O_WB_DstIdx;
    data_t             O_WB_Data;
    logic              O_Bypass_Valid;
    index_t            O_Bypass_DstIdx;
    data_t             O_Bypass_Data;
    logic              O_Empty;

    wb_network_v #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .I_Valid         (I_Valid),
        .I_DstIdx        (I_DstIdx),
        .I_Data          (I_Data),
        .O_Ready         (O_Ready),
        .I_Stall         (I_Stall),
        .O_WB_Req        (O_WB_Req),
        .O_WB_DstIdx     (O_WB_DstIdx),
        .O_WB_Data       (O_WB_Data),
        .O_Bypass_Valid  (O_Bypass_Valid),
        .O_Bypass_DstIdx (O_Bypass_DstIdx),
        .O_Bypass_Data   (O_Bypass_Data),
        .O_Empty         (O_Empty)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per source, a rotating start point, a single output slot.
    wb_entry_t mq [NS][$];
    int        m_ptr;
    logic      m_req;
    wb_entry_t m_out;

    task automatic model_clear();
        for (int s = 0; s < NS; s++) mq[s].delete();
        m_ptr = 0;
        m_req = 1'b0;
        m_out = '0;
    endtask

    task automatic model_step();
        logic [NS-1:0] acc;
        int            win;
        win = -1;
        for (int s = 0; s < NS; s++) acc[s] = I_Valid[s] && (mq[s].size() < DEPTH);
        if (!I_Stall) begin
            for (int k = 0; k < NS; k++) begin
                if (win < 0 && mq[(m_ptr + k) % NS].size() > 0) win = (m_ptr + k) % NS;
            end
        end
        if (win >= 0) begin
            m_out = mq[win].pop_front();
            m_req = 1'b1;
            m_ptr = (win + 1) % NS;
        end else begin
            m_out = '0;
            m_req = 1'b0;
        end
        for (int s = 0; s < NS; s++)
            if (acc[s]) mq[s].push_back('{idx: I_DstIdx[s], data: I_Data[s]});
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_clear();
        else       model_step();
    end

    // Observed write log, used by the directed scenarios.
    int     wr_count = 0;
    index_t wr_log [$];

    initial begin
        forever begin
            @(posedge clock);
            #1;
            begin
                logic exp_empty;
                exp_empty = !m_req;
                for (int s = 0; s < NS; s++) begin
                    check($sformatf("ready[%0d]", s), 64'(O_Ready[s]), 64'(mq[s].size() < DEPTH));
                    if (mq[s].size() != 0) exp_empty = 1'b0;
                end
                check("wb_req",  64'(O_WB_Req),    64'(m_req));
                check("wb_idx",  64'(O_WB_DstIdx), 64'(m_out.idx));
                check("wb_data", 64'(O_WB_Data),   64'(m_out.data));
                check("empty",   64'(O_Empty),     64'(exp_empty));
`ifdef WB_NETWORK_BYPASS_EN
                check("byp_valid", 64'(O_Bypass_Valid),  64'(m_req));
                check("byp_idx",   64'(O_Bypass_DstIdx), 64'(m_out.idx));
                check("byp_data",  64'(O_Bypass_Data),   64'(m_out.data));
`else
                check("byp_valid", 64'(O_Bypass_Valid),  64'd0);
                check("byp_idx",   64'(O_Bypass_DstIdx), 64'd0);
                check("byp_data",  64'(O_Bypass_Data),   64'd0);
`endif
                if (O_WB_Req) begin
                    wr_count++;
                    wr_log.push_back(O_WB_DstIdx);
                end
            end
        end
    end

    task automatic idle_inputs();
        I_Valid  = '0;
        I_DstIdx = '0;
        I_Data   = '0;
        I_Stall  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(O_Ready),        64'b111);
        check({tag, "_req"},   64'(O_WB_Req),       64'd0);
        check({tag, "_idx"},   64'(O_WB_DstIdx),    64'd0);
        check({tag, "_data"},  64'(O_WB_Data),      64'd0);
        check({tag, "_bypv"},  64'(O_Bypass_Valid), 64'd0);
        check({tag, "_empty"}, 64'(O_Empty),        64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("rst_init");
        reset = 1'b0;

        // Single push on src1: write visible two edges later, empty one cycle after.
        I_Valid[1] = 1'b1; I_DstIdx[1] = 5'd5; I_Data[1] = 32'hA5;
        @(negedge clock);
        idle_inputs();
        check("single_t1_req", 64'(O_WB_Req), 64'd0);
        @(negedge clock);
        check("single_t2_req",  64'(O_WB_Req),    64'd1);
        check("single_t2_idx",  64'(O_WB_DstIdx), 64'd5);
        check("single_t2_data", 64'(O_WB_Data),   64'hA5);
        @(negedge clock);
        check("single_t3_empty", 64'(O_Empty), 64'd1);

        // Three simultaneous pushes from pointer 0, then a second round to confirm the pointer wrapped.
        do_reset();
        I_Valid = 3'b111;
        I_DstIdx[0] = 5'd1; I_DstIdx[1] = 5'd2; I_DstIdx[2] = 5'd3;
        I_Data[0] = 32'h11; I_Data[1] = 32'h22; I_Data[2] = 32'h33;
        @(negedge clock);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("rr1_req%0d", i), 64'(O_WB_Req),    64'd1);
            check($sformatf("rr1_idx%0d", i), 64'(O_WB_DstIdx), 64'(i + 1));
        end
        I_Valid = 3'b111;
        I_DstIdx[0] = 5'd4; I_DstIdx[1] = 5'd5; I_DstIdx[2] = 5'd6;
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rr2_idx%0d", i), 64'(O_WB_DstIdx), 64'(i + 4));
            @(negedge clock);
        end

        // Five pushes on src0 under stall: the fifth meets a full FIFO.
        I_Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            I_Valid[0] = 1'b1; I_DstIdx[0] = index_t'(10 + i); I_Data[0] = 32'(256 + i);
            check($sformatf("full_ready%0d", i), 64'(O_Ready[0]), (i < 4) ? 64'd1 : 64'd0);
            @(negedge clock);
        end
        idle_inputs();
        wr_log.delete();
        base = wr_count;
        repeat (8) @(negedge clock);
        check("full_writes", 64'(wr_count - base), 64'd4);
        for (int i = 0; i < 4; i++)
            if (wr_log.size() > i) check($sformatf("full_order%0d", i), 64'(wr_log[i]), 64'(10 + i));

        // One-cycle stall pulse mid-stream: exactly one bubble.
        I_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            I_Valid[2] = 1'b1; I_DstIdx[2] = index_t'(20 + i); I_Data[2] = 32'(i);
            @(negedge clock);
        end
        idle_inputs();
        I_Stall = 1'b1;
        wr_log.delete();
        @(negedge clock);
        I_Stall = 1'b0;
        @(negedge clock);
        check("pulse_req1", 64'(O_WB_Req), 64'd1);
        I_Stall = 1'b1;
        @(negedge clock);
        check("pulse_req2", 64'(O_WB_Req), 64'd0);
        I_Stall = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            @(negedge clock);
            check($sformatf("pulse_req%0d", i), 64'(O_WB_Req), 64'd1);
        end
        @(negedge clock);
        check("pulse_req6", 64'(O_WB_Req), 64'd0);
        check("pulse_count", 64'(wr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (wr_log.size() > i) check($sformatf("pulse_order%0d", i), 64'(wr_log[i]), 64'(20 + i));

        // Asynchronous reset with data buffered and a write in flight.
        I_Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            I_Valid = 3'b011;
            I_DstIdx[0] = index_t'(30 + i); I_DstIdx[1] = index_t'(40 + i);
            @(negedge clock);
        end
        idle_inputs();
        @(negedge clock);
        I_Stall = 1'b1;
        check("arst_pre_req", 64'(O_WB_Req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("arst");
        @(negedge clock);
        reset = 1'b0;
        I_Stall = 1'b0;
        base = wr_count;
        repeat (6) @(negedge clock);
        check("arst_writes", 64'(wr_count - base), 64'd0);
        check("arst_empty",  64'(O_Empty),         64'd1);

        // Randomized traffic, light then heavy stall, with one asynchronous reset in between.
        for (int c = 0; c < 3000; c++) begin
            I_Valid = NS'($urandom);
            for (int s = 0; s < NS; s++) begin
                I_DstIdx[s] = index_t'($urandom);
                I_Data[s]   = data_t'($urandom);
            end
            I_Stall = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                #3;
                reset = 1'b1;
                #1;
                check("rand_arst_req", 64'(O_WB_Req), 64'd0);
                @(negedge clock);
                reset = 1'b0;
            end else begin
                @(negedge clock);
            end
        end
        idle_inputs();
        repeat (20) @(negedge clock);
        check("drain_empty", 64'(O_Empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_network_v.md
WB_NETWORK_V -- requirements
Module: wb_network_v

Interface
REQ-001 Parameter NUM_SRC, default 3: number of execution-pipe result sources (source 0 = MA, 1 = logic/shift, 2 = load).
REQ-002 Parameter FIFO_DEPTH, default 4: entries per source FIFO; power of two, at least 2.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 I_Valid  in  [NUM_SRC]  per-source result valid.
REQ-006 I_DstIdx  in  index_t[NUM_SRC]  per-source destination register index.
REQ-007 I_Data  in  data_t[NUM_SRC]  per-source result data.
REQ-008 O_Ready  out  [NUM_SRC]  per-source accept; high when that source's FIFO is not full.
REQ-009 I_Stall  in  1  register-file write port busy; blocks new grants.
REQ-010 O_WB_Req  out  1  register-file write strobe.
REQ-011 O_WB_DstIdx  out  index_t  register-file write index.
REQ-012 O_WB_Data  out  data_t  register-file write data.
REQ-013 O_Bypass_Valid / O_Bypass_DstIdx / O_Bypass_Data  out  1 / index_t / data_t  forwarding to the operand network's WB compare path.
REQ-014 O_Empty  out  1  all FIFOs empty and no write in flight; used for drain/commit.

Function
REQ-015 A push into FIFO s SHALL occur on the edge where I_Valid[s] & O_Ready[s]; I_Valid without O_Ready SHALL be ignored and the source holds its data.
REQ-016 O_Ready[s] SHALL derive from the registered FIFO count only; a full FIFO SHALL reject a push even in a cycle where it also pops.
REQ-017 The arbiter SHALL choose, when I_Stall=0, one non-empty FIFO in round-robin order starting at the priority pointer; the winner pops on that edge.
REQ-018 The priority pointer SHALL move to (winner+1) mod NUM_SRC after each grant and SHALL hold when there is no grant.
REQ-019 The output register SHALL load the popped {idx,data} on the grant edge; O_WB_Req=1 for exactly the following cycle, 0 otherwise.
REQ-020 Latency: a result accepted in cycle t into an empty, unstalled, uncontended FIFO SHALL appear on O_WB_* in cycle t+2.
REQ-021 I_Stall=1 in cycle c SHALL suppress the grant in c, so O_WB_Req=0 in c+1; a write already on O_WB_* in c SHALL complete unaffected.
REQ-022 Throughput: one write per cycle sustained while any FIFO is non-empty and I_Stall=0.
REQ-023 Per-source order SHALL be preserved; no ordering across sources is guaranteed.
REQ-024 When O_WB_Req=0, O_WB_DstIdx and O_WB_Data SHALL be driven to 0.
REQ-025 O_Empty SHALL be the AND of all FIFO-empty flags and ~O_WB_Req.

Reset
REQ-026 Reset SHALL clear all FIFO pointers and counts, set the priority pointer to 0, clear the output register, and drop all in-flight results, including mid-operation.
REQ-027 Reset values: O_Ready all 1, O_WB_Req 0, O_WB_DstIdx 0, O_WB_Data 0, all bypass outputs 0, O_Empty 1.

Configuration
REQ-028 With WB_NETWORK_BYPASS_EN defined, O_Bypass_Valid/DstIdx/Data SHALL equal O_WB_Req/DstIdx/Data in the same cycle.
REQ-029 Without WB_NETWORK_BYPASS_EN, all bypass outputs SHALL be constant 0 and no bypass logic is synthesized.

Structure
REQ-030 The types wb_entry_t {index_t idx; data_t data;} and NUM_WB_SRC SHALL reside in pkg_tpu.
REQ-031 The per-source buffer SHALL be a single sub-module WB_FIFO, parameterized by FIFO_DEPTH and instantiated NUM_SRC times.

Verification
REQ-032 Single push on src1 {idx=5, data=0xA5} at t, no stall -> O_WB_Req=1 with idx 5, data 0xA5 at t+2; O_Empty=1 at t+3.
REQ-033 All three sources push in the same cycle {idx 1,2,3}, pointer=0 -> writes idx 1,2,3 on consecutive cycles; pointer returns to 0.
REQ-034 Five pushes on src0 with I_Stall=1 held -> fifth attempt sees O_Ready[0]=0 while FIFO is full; after stall release, exactly four writes in FIFO order.
REQ-035 I_Stall pulsed for one cycle mid-stream -> exactly one bubble on O_WB_Req; no loss and no duplicate.
REQ-036 Reset asserted while two FIFOs hold data -> outputs immediately at reset values; no writes after release; O_Empty=1.
REQ-037 Build both with and without WB_NETWORK_BYPASS_EN -> bypass outputs either mirror O_WB_* cycle-exactly or stay 0 throughout.
